// File: rtl/fft_reorder_if.sv
// Streaming port bundle for the FFT output reorder buffer.
// Input side: bit-reversed samples; output side: natural-order samples.
interface fft_reorder_if #(
    parameter int DATA_W = 16,
    parameter int LOG2N  = 5
);
    logic                     valid_i;
    logic signed [DATA_W-1:0] data_in_r;
    logic signed [DATA_W-1:0] data_in_i;
    logic                     in_ready;
    logic                     valid_o;
    logic                     ready_i;
    logic signed [DATA_W-1:0] data_out_r;
    logic signed [DATA_W-1:0] data_out_i;
    logic [LOG2N-1:0]         index_o;
    logic                     overflow;

    modport master (
        output valid_i, data_in_r, data_in_i, ready_i,
        input  in_ready, valid_o, data_out_r, data_out_i,
        input  index_o, overflow
    );

    modport slave (
        input  valid_i, data_in_r, data_in_i, ready_i,
        output in_ready, valid_o, data_out_r, data_out_i,
        output index_o, overflow
    );
endinterface

// File: rtl/fft_reorder.sv
// Ping-pong frame buffer turning bit-reversed FFT output into
// natural order, with sticky overflow on dropped input samples.
module fft_reorder #(
    parameter int DATA_W = 16,
    parameter int LOG2N  = 5
) (
    input logic          clk,
    input logic          rst,
    fft_reorder_if.slave io
);
    localparam int N = 1 << LOG2N;

    typedef logic [LOG2N-1:0] cnt_t;

    function automatic cnt_t bitrev(input cnt_t a);
        cnt_t r;
        for (int b = 0; b < LOG2N; b++) begin
            r[b] = a[LOG2N-1-b];
        end
        return r;
    endfunction

    logic signed [DATA_W-1:0] mem_r_q [2][N];
    logic signed [DATA_W-1:0] mem_i_q [2][N];

    cnt_t       wcnt_q, wcnt_d;
    cnt_t       rcnt_q, rcnt_d;
    logic       wbank_q, wbank_d;
    logic       rbank_q, rbank_d;
    logic [1:0] full_q, full_d;
    logic       ovf_q, ovf_d;

    logic in_rdy;
    logic accept;
    logic xfer;
    logic wlast;
    logic rlast;

    assign in_rdy = !full_q[wbank_q];
    assign accept = io.valid_i && in_rdy;
    assign xfer   = full_q[rbank_q] && io.ready_i;
    assign wlast  = (wcnt_q == cnt_t'(N - 1));
    assign rlast  = (rcnt_q == cnt_t'(N - 1));

    // Write and read never wrap into the same bank: a write wrap needs
    // its bank empty, a read wrap needs its bank full.
    always_comb begin
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        wbank_d = wbank_q;
        rbank_d = rbank_q;
        full_d  = full_q;
        ovf_d   = ovf_q;
        if (accept) begin
            wcnt_d = cnt_t'(wcnt_q + 1'b1);
            if (wlast) begin
                wbank_d         = !wbank_q;
                full_d[wbank_q] = 1'b1;
            end
        end
        if (io.valid_i && !in_rdy) begin
            ovf_d = 1'b1;
        end
        if (xfer) begin
            rcnt_d = cnt_t'(rcnt_q + 1'b1);
            if (rlast) begin
                rbank_d         = !rbank_q;
                full_d[rbank_q] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            full_q  <= 2'b00;
            ovf_q   <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_r_q[wbank_q][bitrev(wcnt_q)] <= io.data_in_r;
            mem_i_q[wbank_q][bitrev(wcnt_q)] <= io.data_in_i;
        end
    end

    assign io.in_ready   = in_rdy;
    assign io.valid_o    = full_q[rbank_q];
    assign io.data_out_r = mem_r_q[rbank_q][rcnt_q];
    assign io.data_out_i = mem_i_q[rbank_q][rcnt_q];
    assign io.index_o    = rcnt_q;
    assign io.overflow   = ovf_q;
endmodule
